xalu_nibble_seq: RTL and testbench

- Nibble-serial sequencer sitting directly upstream of the team's 4-bit ALU slice.
- Accepts wide operands, a 3-bit function code and a complement flag over a valid/ready handshake.
- Feeds the slice one nibble per cycle and registers the inter-nibble carry, so carries and shifts propagate across the word.
- Reassembles the result nibbles and accumulates word-level status flags.

---
 rtl/xalu_nibble_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_xalu_nibble_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/xalu_nibble_seq.sv
// xalu_nibble_seq: nibble-serial sequencer in front of the 4-bit ALU slice.
// A request is latched over in_valid/in_ready. The operands are then fed to the
// slice one nibble per cycle, with the inter-nibble carry held in a register.
// The result word and the word-level flags are published in DONE.
// Optional feature macro: XALU_SEQ_OVF_EN. It adds the signed-overflow output ovf for ADD.
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic [2:0]             func,
  input  logic                   com,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   zero,
  output logic                   neg_zero,
  output logic                   equ,
`ifdef XALU_SEQ_OVF_EN
  output logic                   ovf,
`endif
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_f,
  output logic                   alu_com,
  output logic                   alu_ci_left,
  output logic                   alu_ci_right,
  input  logic [3:0]             alu_d,
  input  logic                   alu_co_left,
  input  logic                   alu_co_right,
  input  logic                   alu_zero,
  input  logic                   alu_neg_zero,
  input  logic                   alu_equ
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SHR = 3'd6;
  localparam logic [2:0] F_SHL = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]              idx_q, idx_d;
  logic [NIBBLES-1:0][3:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [2:0]                 func_q, func_d;
  logic                       com_q, com_d;
  logic                       cy_q, cy_d;
  logic                       zacc_q, zacc_d, nacc_q, nacc_d, eacc_q, eacc_d;
  logic [4*NIBBLES-1:0]       result_q, result_d;
  logic                       cout_q, cout_d;
  logic                       zero_q, zero_d, neg_zero_q, neg_zero_d, equ_q, equ_d;
  logic                       ovld_q, ovld_d;
  logic                       last;
  logic                       is_shr;
`ifdef XALU_SEQ_OVF_EN
  logic                       msb_q, msb_d;
  logic                       ovf_q, ovf_d;
`endif

  // Next-state, slice drive and datapath update; every target defaulted first.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    func_d       = func_q;
    com_d        = com_q;
    cy_d         = cy_q;
    acc_d        = acc_q;
    zacc_d       = zacc_q;
    nacc_d       = nacc_q;
    eacc_d       = eacc_q;
    result_d     = result_q;
    cout_d       = cout_q;
    zero_d       = zero_q;
    neg_zero_d   = neg_zero_q;
    equ_d        = equ_q;
    ovld_d       = ovld_q;
`ifdef XALU_SEQ_OVF_EN
    msb_d        = msb_q;
    ovf_d        = ovf_q;
`endif
    in_ready     = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_f        = '0;
    alu_com      = 1'b0;
    alu_ci_left  = 1'b0;
    alu_ci_right = 1'b0;
    is_shr       = (func_q == F_SHR);
    // SHR walks MSB->LSB, everything else LSB->MSB
    last         = is_shr ? (idx_q == '0) : (idx_q == IW'(NIBBLES-1));

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          func_d  = func;
          com_d   = com;
          cy_d    = cin;
          zacc_d  = 1'b1;
          nacc_d  = 1'b1;
          eacc_d  = 1'b1;
          idx_d   = (func == F_SHR) ? IW'(NIBBLES-1) : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        alu_a         = a_q[idx_q];
        alu_b         = b_q[idx_q];
        alu_f         = func_q;
        alu_com       = com_q;
        alu_ci_left   = is_shr ? cy_q : 1'b0;
        alu_ci_right  = is_shr ? 1'b0 : cy_q;
        acc_d[idx_q]  = alu_d;
        cy_d          = is_shr ? alu_co_right : alu_co_left;
        zacc_d        = zacc_q & alu_zero;
        nacc_d        = nacc_q & alu_neg_zero;
        eacc_d        = eacc_q & alu_equ;
`ifdef XALU_SEQ_OVF_EN
        // com only inverts data, so undo it to recover the true sum MSB
        if (last) msb_d = alu_d[3] ^ com_q;
`endif
        if (last) state_d = DONE;
        else      idx_d   = is_shr ? (idx_q - IW'(1)) : (idx_q + IW'(1));
      end
      DONE: begin
        // First DONE cycle publishes the word; out_valid follows and holds until taken.
        if (!ovld_q) begin
          ovld_d     = 1'b1;
          result_d   = acc_q;
          cout_d     = ((func_q == F_ADD) || (func_q == F_SHL) || is_shr) ? cy_q : 1'b0;
          zero_d     = zacc_q;
          neg_zero_d = nacc_q;
          equ_d      = eacc_q;
`ifdef XALU_SEQ_OVF_EN
          ovf_d      = (func_q == F_ADD) &&
                       (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                       (msb_q != a_q[NIBBLES-1][3]);
`endif
        end else if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath and published-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      func_q     <= '0;
      com_q      <= 1'b0;
      cy_q       <= 1'b0;
      acc_q      <= '0;
      zacc_q     <= 1'b1;
      nacc_q     <= 1'b1;
      eacc_q     <= 1'b1;
      result_q   <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b1;
      neg_zero_q <= 1'b0;
      equ_q      <= 1'b1;
      ovld_q     <= 1'b0;
`ifdef XALU_SEQ_OVF_EN
      msb_q      <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      func_q     <= func_d;
      com_q      <= com_d;
      cy_q       <= cy_d;
      acc_q      <= acc_d;
      zacc_q     <= zacc_d;
      nacc_q     <= nacc_d;
      eacc_q     <= eacc_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      neg_zero_q <= neg_zero_d;
      equ_q      <= equ_d;
      ovld_q     <= ovld_d;
`ifdef XALU_SEQ_OVF_EN
      msb_q      <= msb_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign out_valid = ovld_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign neg_zero  = neg_zero_q;
  assign equ       = equ_q;
`ifdef XALU_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Directed bench for xalu_nibble_seq with a behavioural 4-bit ALU slice in the loop.
module tb_xalu_nibble_seq;

  localparam int NIBBLES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] op_a = '0, op_b = '0;
  logic [2:0]  func = '0;
  logic        com = 1'b0, cin = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] result;
  logic        cout, zero, neg_zero, equ;
`ifdef XALU_SEQ_OVF_EN
  logic        ovf;
`endif
  logic [3:0]  alu_a, alu_b, alu_d;
  logic [2:0]  alu_f;
  logic        alu_com, alu_ci_left, alu_ci_right;
  logic        alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  xalu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .func(func), .com(com), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .neg_zero(neg_zero), .equ(equ),
`ifdef XALU_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_com(alu_com),
    .alu_ci_left(alu_ci_left), .alu_ci_right(alu_ci_right),
    .alu_d(alu_d), .alu_co_left(alu_co_left), .alu_co_right(alu_co_right),
    .alu_zero(alu_zero), .alu_neg_zero(alu_neg_zero), .alu_equ(alu_equ)
  );

  // Slice model: com inverts data only; flags describe the driven data.
  logic [4:0] sl_sum;
  logic [3:0] sl_raw;
  always_comb begin
    sl_sum       = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_ci_right};
    sl_raw       = '0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      3'd0: begin sl_raw = sl_sum[3:0]; alu_co_left = sl_sum[4]; end
      3'd1: sl_raw = alu_a & alu_b;
      3'd2: sl_raw = alu_a | alu_b;
      3'd3: sl_raw = alu_a ^ alu_b;
      3'd4: sl_raw = alu_a;
      3'd5: sl_raw = alu_b;
      3'd6: begin sl_raw = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      default: begin sl_raw = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
    endcase
    alu_d        = sl_raw ^ {4{alu_com}};
    alu_zero     = (alu_d == 4'h0);
    alu_neg_zero = (alu_d == 4'hF);
    alu_equ      = (alu_a == alu_b);
  end

  // Issue one op and wait for out_valid; lat = posedges from accept to out_valid (99 on timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                        input logic c, input logic ci, output int lat);
    int guard;
    guard = 0;
    lat   = 99;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    op_a = a; op_b = b; func = f; com = c; cin = ci;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (result !== 16'h0000) begin errs++; $display("FAIL reset_result got %h want 0000", result); end
    vecs++; if ({cout, zero, neg_zero, equ} !== 4'b0101) begin errs++; $display("FAIL reset_flags got %b want 0101", {cout, zero, neg_zero, equ}); end
    vecs++; if ({alu_a, alu_b, alu_f, alu_com, alu_ci_left, alu_ci_right} !== 14'h0) begin errs++; $display("FAIL reset_slice_idle got %h want 0", {alu_a, alu_b, alu_f, alu_com, alu_ci_left, alu_ci_right}); end
  endtask

  task automatic test_add();
    int lat;
    run_op(16'h00FF, 16'h0001, 3'd0, 1'b0, 1'b0, lat);
    vecs++; if (lat !== 5) begin errs++; $display("FAIL add_latency got %0d want 5", lat); end
    vecs++; if (result !== 16'h0100) begin errs++; $display("FAIL add1_result got %h want 0100", result); end
    vecs++; if ({cout, zero, neg_zero, equ} !== 4'b0000) begin errs++; $display("FAIL add1_flags got %b want 0000", {cout, zero, neg_zero, equ}); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL done_in_ready got %b want 0", in_ready); end
    release_op();
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL release_idle got rdy=%b vld=%b want 1 0", in_ready, out_valid); end

    run_op(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0, lat);
    vecs++; if (result !== 16'h0000) begin errs++; $display("FAIL add2_result got %h want 0000", result); end
    vecs++; if ({cout, zero, neg_zero} !== 3'b110) begin errs++; $display("FAIL add2_flags got %b want 110", {cout, zero, neg_zero}); end
`ifdef XALU_SEQ_OVF_EN
    vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL add2_ovf got %b want 0", ovf); end
`endif
    release_op();

    run_op(16'h7FFF, 16'h0001, 3'd0, 1'b0, 1'b0, lat);
    vecs++; if (result !== 16'h8000 || cout !== 1'b0) begin errs++; $display("FAIL add3 got %h/%b want 8000/0", result, cout); end
`ifdef XALU_SEQ_OVF_EN
    vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL add3_ovf got %b want 1", ovf); end
`endif
    release_op();
  endtask

  task automatic test_shift();
    int lat;
    run_op(16'h8001, 16'h0000, 3'd6, 1'b0, 1'b1, lat);
    vecs++; if (lat !== 5) begin errs++; $display("FAIL shr_latency got %0d want 5", lat); end
    vecs++; if (result !== 16'hC000 || cout !== 1'b1) begin errs++; $display("FAIL shr got %h/%b want c000/1", result, cout); end
    release_op();
    run_op(16'h8001, 16'h0000, 3'd7, 1'b0, 1'b0, lat);
    vecs++; if (result !== 16'h0002 || cout !== 1'b1) begin errs++; $display("FAIL shl got %h/%b want 0002/1", result, cout); end
    release_op();
  endtask

  task automatic test_xor_com();
    int lat;
    run_op(16'h1234, 16'h1234, 3'd3, 1'b1, 1'b0, lat);
    vecs++; if (result !== 16'hFFFF) begin errs++; $display("FAIL xor_com_result got %h want ffff", result); end
    vecs++; if ({cout, zero, neg_zero, equ} !== 4'b0011) begin errs++; $display("FAIL xor_com_flags got %b want 0011", {cout, zero, neg_zero, equ}); end
    release_op();
    // cin=1 must not leak into cout for a logic function
    run_op(16'hF0F0, 16'hFF00, 3'd2, 1'b0, 1'b1, lat);
    vecs++; if (result !== 16'hFFF0 || cout !== 1'b0 || equ !== 1'b0) begin errs++; $display("FAIL or got %h/%b/%b want fff0/0/0", result, cout, equ); end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h1234, 16'h1111, 3'd0, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      op_a = 16'hFFFF; op_b = 16'hFFFF; func = 3'd1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vecs++; if (result !== 16'h2345 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0)
        begin errs++; $display("FAIL hold_%0d got %h vld=%b rdy=%b z=%b want 2345 1 0 0", i, result, out_valid, in_ready, zero); end
    end
    in_valid = 1'b0;
    release_op();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL hold_release got %b want 1", in_ready); end
    run_op(16'hF0F0, 16'hFF00, 3'd1, 1'b0, 1'b0, lat);
    vecs++; if (result !== 16'hF000 || lat !== 5) begin errs++; $display("FAIL after_hold got %h lat %0d want f000 lat 5", result, lat); end
    release_op();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'hFFFF; func = 3'd0; com = 1'b0; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL midrst_hs got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    vecs++; if (result !== 16'h0000 || cout !== 1'b0) begin errs++; $display("FAIL midrst_result got %h/%b want 0000/0", result, cout); end
    run_op(16'h0001, 16'h0001, 3'd0, 1'b0, 1'b0, lat);
    vecs++; if (result !== 16'h0002 || lat !== 5) begin errs++; $display("FAIL midrst_next got %h lat %0d want 0002 lat 5", result, lat); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_xor_com();
    test_backpressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
